// File: rtl/dw_addsub_pipe.sv
// dw_addsub_pipe: parametrised pipelined adder/subtractor.
// The carry chain is cut into SEGS slices of SEG_W bits. Each stage adds its
// slice and hands the carry to the next registered stage. Upper operand
// slices and the mode bits travel with their transaction. Lower result
// slices ride forward in the same vector that still holds the pending bits of a.
//
// Handshake: a transfer happens on a side when valid & ready are both high.
// The pipeline advances as one unit (w_adv = out_ready | ~out_valid).
// in_ready equals w_adv. While w_adv is low, every stage holds, bubbles included.
// out_valid, res, co and ovf stay stable until out_ready is seen.
// WIDTH must be a multiple of SEGS, and WIDTH must be at least 2.
module dw_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEGS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op_sub,
  input  logic             tc,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             co,
  output logic             ovf
);

  localparam int SEG_W = WIDTH / SEGS;
  localparam int LAST  = SEGS - 1;

  // The pending b bits shrink by one slice per stage. They are packed into a
  // single flat bus. Stage k owns WIDTH - k*SEG_W bits, starting at b_off(k).
  function automatic int b_off(input int k);
    return k * WIDTH - (SEG_W * k * (k - 1)) / 2;
  endfunction

  localparam int BTOT = b_off(SEGS);

  logic                 w_adv;
  logic [SEGS-1:0]      w_vld;
  logic [SEGS-1:0]      w_c;
  logic [SEGS-1:0]      w_op;
  logic [SEGS-1:0]      w_tc;
  logic [SEGS-1:0]      w_sat;
  logic [WIDTH-1:0]     w_p    [SEGS];
  logic [WIDTH-1:0]     w_pout [SEGS];
  logic [SEG_W:0]       w_slice[SEGS];
  logic [BTOT-1:0]      w_bbus;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_res;
  logic                 r_co;
  logic                 r_ovf;

  assign w_adv    = out_ready | ~r_out_valid;
  assign in_ready = w_adv;

  for (genvar k = 0; k < SEGS; k++) begin : g_stg
    localparam int BW = WIDTH - k * SEG_W;
    localparam logic [WIDTH-1:0] SMASK = WIDTH'({SEG_W{1'b1}}) << (k * SEG_W);

    if (k == 0) begin : g_head
      // Stage 0 reads the ports directly. b is inverted and the carry-in is
      // flipped for subtraction, so a - b - ci = a + ~b + ~ci.
      assign w_vld[0] = in_valid;
      assign w_p[0]   = a;
      assign w_bbus[0 +: WIDTH] = op_sub ? ~b : b;
      assign w_c[0]   = op_sub ? ~ci : ci;
      assign w_op[0]  = op_sub;
      assign w_tc[0]  = tc;
      assign w_sat[0] = sat;
    end else begin : g_reg
      logic             r_vld;
      logic             r_c;
      logic             r_op;
      logic             r_tc;
      logic             r_sat;
      logic [WIDTH-1:0] r_p;
      logic [BW-1:0]    r_b;

      // Register the previous stage's partial result, carry, pending b bits and modes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
          r_c   <= 1'b0;
          r_op  <= 1'b0;
          r_tc  <= 1'b0;
          r_sat <= 1'b0;
          r_p   <= '0;
          r_b   <= '0;
        end else if (w_adv) begin
          r_vld <= w_vld[k-1];
          r_c   <= w_slice[k-1][SEG_W];
          r_op  <= w_op[k-1];
          r_tc  <= w_tc[k-1];
          r_sat <= w_sat[k-1];
          r_p   <= w_pout[k-1];
          r_b   <= w_bbus[b_off(k-1) + SEG_W +: BW];
        end
      end

      assign w_vld[k] = r_vld;
      assign w_c[k]   = r_c;
      assign w_op[k]  = r_op;
      assign w_tc[k]  = r_tc;
      assign w_sat[k] = r_sat;
      assign w_p[k]   = r_p;
      assign w_bbus[b_off(k) +: BW] = r_b;
    end

    assign w_slice[k] = {1'b0, w_p[k][k*SEG_W +: SEG_W]}
                      + {1'b0, w_bbus[b_off(k) +: SEG_W]}
                      + (SEG_W + 1)'(w_c[k]);
    assign w_pout[k]  = (w_p[k] & ~SMASK)
                      | (WIDTH'(w_slice[k][SEG_W-1:0]) << (k * SEG_W));
  end

  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_res_n;
  logic             w_cout;
  logic             w_co_n;
  logic             w_as;
  logic             w_bxs;
  logic             w_sovf;
  logic             w_ovf_n;

  assign w_r     = w_pout[LAST];
  assign w_cout  = w_slice[LAST][SEG_W];
  assign w_as    = w_p[LAST][WIDTH-1];
  assign w_bxs   = w_bbus[BTOT-1];
  // A subtract reports a borrow, which is the inverse of the adder carry.
  assign w_co_n  = w_op[LAST] ^ w_cout;
  // Signed overflow occurs when a and the effective addend (b, or ~b for a
  // subtract) share a sign and the result sign differs from that sign.
  assign w_sovf  = (w_as == w_bxs) & (w_r[WIDTH-1] != w_as);
  assign w_ovf_n = w_tc[LAST] ? w_sovf : w_co_n;

  // Clamp the raw result on overflow when saturation is requested.
  always_comb begin
    w_res_n = w_r;
    if (w_sat[LAST] && w_ovf_n) begin
      if (w_tc[LAST]) begin
        w_res_n = w_as ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        w_res_n = w_op[LAST] ? '0 : '1;
      end
    end
  end

  // Output register. Data is loaded only for real transactions; bubbles clear valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_co        <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_vld[LAST];
      if (w_vld[LAST]) begin
        r_res <= w_res_n;
        r_co  <= w_co_n;
        r_ovf <= w_ovf_n;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign co        = r_co;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_dw_addsub_pipe.sv
// Bench for dw_addsub_pipe. Instance 0 (8/2) takes the directed cases.
// All five configurations then get randomized streams checked against an arithmetic model.
module tb_dw_addsub_pipe;

  localparam int NI   = 5;
  localparam int NVEC = 10000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NI-1:0]   t_iv, t_or, t_ci, t_op, t_tc, t_sat;
  logic [31:0]     t_a [NI];
  logic [31:0]     t_b [NI];
  wire  [NI-1:0]   o_ir, o_ov, o_co, o_of;
  wire  [7:0]      w_res0, w_res1, w_res2;
  wire  [15:0]     w_res3;
  wire  [31:0]     w_res4;

  logic [33:0]     exp_q [NI][$];
  int              n_sent [NI];
  int              n_recv [NI];
  int              n_tests = 0;
  int              n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dw_addsub_pipe #(.WIDTH(8), .SEGS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv[0]), .in_ready(o_ir[0]),
    .a(t_a[0][7:0]), .b(t_b[0][7:0]), .ci(t_ci[0]), .op_sub(t_op[0]), .tc(t_tc[0]),
    .sat(t_sat[0]), .out_valid(o_ov[0]), .out_ready(t_or[0]), .res(w_res0),
    .co(o_co[0]), .ovf(o_of[0]));
  dw_addsub_pipe #(.WIDTH(8), .SEGS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv[1]), .in_ready(o_ir[1]),
    .a(t_a[1][7:0]), .b(t_b[1][7:0]), .ci(t_ci[1]), .op_sub(t_op[1]), .tc(t_tc[1]),
    .sat(t_sat[1]), .out_valid(o_ov[1]), .out_ready(t_or[1]), .res(w_res1),
    .co(o_co[1]), .ovf(o_of[1]));
  dw_addsub_pipe #(.WIDTH(8), .SEGS(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv[2]), .in_ready(o_ir[2]),
    .a(t_a[2][7:0]), .b(t_b[2][7:0]), .ci(t_ci[2]), .op_sub(t_op[2]), .tc(t_tc[2]),
    .sat(t_sat[2]), .out_valid(o_ov[2]), .out_ready(t_or[2]), .res(w_res2),
    .co(o_co[2]), .ovf(o_of[2]));
  dw_addsub_pipe #(.WIDTH(16), .SEGS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv[3]), .in_ready(o_ir[3]),
    .a(t_a[3][15:0]), .b(t_b[3][15:0]), .ci(t_ci[3]), .op_sub(t_op[3]), .tc(t_tc[3]),
    .sat(t_sat[3]), .out_valid(o_ov[3]), .out_ready(t_or[3]), .res(w_res3),
    .co(o_co[3]), .ovf(o_of[3]));
  dw_addsub_pipe #(.WIDTH(32), .SEGS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_iv[4]), .in_ready(o_ir[4]),
    .a(t_a[4]), .b(t_b[4]), .ci(t_ci[4]), .op_sub(t_op[4]), .tc(t_tc[4]),
    .sat(t_sat[4]), .out_valid(o_ov[4]), .out_ready(t_or[4]), .res(w_res4),
    .co(o_co[4]), .ovf(o_of[4]));

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int i);
    return (i == 3) ? 16 : (i == 4) ? 32 : 8;
  endfunction

  function automatic logic [33:0] get_out(input int i);
    case (i)
      0:       return {24'd0, w_res0, o_co[0], o_of[0]};
      1:       return {24'd0, w_res1, o_co[1], o_of[1]};
      2:       return {24'd0, w_res2, o_co[2], o_of[2]};
      3:       return {16'd0, w_res3, o_co[3], o_of[3]};
      default: return {w_res4, o_co[4], o_of[4]};
    endcase
  endfunction

  // Reference model. It computes the true mathematical result and reads carry,
  // overflow and clamping off that result's range. Result packs {res[31:0], co, ovf}.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] a, b,
                                            input logic ci, op, tc, sat);
    longint umax, smax, smin, ua, ub, sa, sb, ut, st, lc;
    logic   co_v, ovf_v;
    logic [31:0] r;
    umax = (64'sd1 <<< w) - 1;
    smax = (64'sd1 <<< (w - 1)) - 1;
    smin = -smax - 1;
    ua = longint'({32'd0, a}) & umax;
    ub = longint'({32'd0, b}) & umax;
    sa = (ua > smax) ? ua - umax - 1 : ua;
    sb = (ub > smax) ? ub - umax - 1 : ub;
    lc = ci ? 1 : 0;
    ut = op ? ua - ub - lc : ua + ub + lc;
    st = op ? sa - sb - lc : sa + sb + lc;
    co_v  = op ? (ut < 0) : (ut > umax);
    ovf_v = tc ? (st > smax || st < smin) : co_v;
    if (sat && ovf_v) begin
      if (tc) r = 32'((st > smax ? smax : smin) & umax);
      else    r = 32'((ut < 0) ? 0 : umax);
    end else begin
      r = 32'(ut & umax);
    end
    return {r, co_v, ovf_v};
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m, msb;
    m   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msb = 32'd1 << (w - 1);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return msb;
      3:       return msb - 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_vec(input int i, input logic [31:0] a, b, input logic ci, op, tc, sat);
    t_a[i] = a; t_b[i] = b; t_ci[i] = ci; t_op[i] = op; t_tc[i] = tc; t_sat[i] = sat;
  endtask

  task automatic rand_vec(input int i);
    set_vec(i, pick(wid(i)), pick(wid(i)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Scoreboard step, called between edges: push on accept, pop and compare on emit.
  task automatic step_book(input int i);
    logic [33:0] e;
    if (t_iv[i] && o_ir[i]) begin
      exp_q[i].push_back(ref_model(wid(i), t_a[i], t_b[i], t_ci[i], t_op[i], t_tc[i], t_sat[i]));
      n_sent[i]++;
    end
    if (o_ov[i] && t_or[i]) begin
      if (exp_q[i].size() == 0) begin
        check($sformatf("inst%0d_unexpected_out", i), 1, 0);
      end else begin
        e = exp_q[i].pop_front();
        check($sformatf("inst%0d_w%0d_res_co_ovf", i, wid(i)), get_out(i), e);
        n_recv[i]++;
      end
    end
  endtask

  // Single transaction on instance 0, with the latency measured in clock edges after acceptance.
  task automatic direct(input string tag, input logic [7:0] a, b, input logic ci, op, tc, sat,
                        input logic [7:0] e_res, input logic e_co, e_ovf);
    int lat;
    @(negedge clk);
    set_vec(0, {24'd0, a}, {24'd0, b}, ci, op, tc, sat);
    t_iv[0] = 1'b1; t_or[0] = 1'b1;
    #1 check({tag, "_in_ready"}, o_ir[0], 1);
    @(posedge clk);
    @(negedge clk);
    t_iv[0] = 1'b0;
    lat = 1;
    while (!o_ov[0] && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_res"}, w_res0, e_res);
    check({tag, "_co"}, o_co[0], e_co);
    check({tag, "_ovf"}, o_of[0], e_ovf);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    bit busy;
    rst_n = 1'b0;
    t_iv = '0; t_or = '1;
    for (int i = 0; i < NI; i++) begin
      set_vec(i, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_sent[i] = 0; n_recv[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_out_valid", o_ov[0], 0);
    check("reset_res", w_res0, 0);
    check("reset_co", o_co[0], 0);
    check("reset_ovf", o_of[0], 0);
    check("reset_in_ready", o_ir[0], 1);
    rst_n = 1'b1;

    // unsigned borrow, then saturation, then the signed edge cases
    direct("t1_sub",     8'h00, 8'h01, 0, 1, 0, 0, 8'hFF, 1, 1);
    direct("t1_sub_sat", 8'h00, 8'h01, 0, 1, 0, 1, 8'h00, 1, 1);
    direct("t2_add_tc",  8'h7F, 8'h01, 0, 0, 1, 0, 8'h80, 0, 1);
    direct("t2_add_sat", 8'h7F, 8'h01, 0, 0, 1, 1, 8'h7F, 0, 1);
    direct("t2_sub_sat", 8'h80, 8'h01, 0, 1, 1, 1, 8'h80, 0, 1);
    // carries and borrows across the segment boundary
    direct("t3_add_0f",  8'h0F, 8'h01, 0, 0, 0, 0, 8'h10, 0, 0);
    direct("t3_add_ci",  8'hFF, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1);
    direct("t3_sub_10",  8'h10, 8'h01, 0, 1, 0, 0, 8'h0F, 0, 0);

    // stream of 6 transactions with a downstream stall in cycles 3..5
    n_sent[0] = 0; n_recv[0] = 0;
    cyc = 0;
    while ((n_sent[0] < 6 || exp_q[0].size() != 0) && cyc < 40) begin
      @(negedge clk);
      t_or[0] = !(cyc >= 3 && cyc <= 5);
      t_iv[0] = (n_sent[0] < 6);
      if (n_sent[0] < 6) rand_vec(0);
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        check("t4_stall_out_valid", o_ov[0], 1);
        check("t4_stall_in_ready", o_ir[0], 0);
        if (exp_q[0].size() != 0) check("t4_stall_hold", get_out(0), exp_q[0][0]);
      end
      step_book(0);
      cyc++;
    end
    check("t4_count", n_recv[0], 6);
    check("t4_leftover", exp_q[0].size(), 0);

    // reset with two transactions in flight
    @(negedge clk);
    set_vec(0, 32'h00, 32'h01, 0, 1, 0, 0); t_iv[0] = 1'b1; t_or[0] = 1'b1;
    @(negedge clk);
    set_vec(0, 32'h7F, 32'h01, 0, 0, 1, 0);
    @(negedge clk);
    t_iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", o_ov[0], 0);
    check("t5_rst_res", w_res0, 0);
    check("t5_rst_co", o_co[0], 0);
    check("t5_rst_ovf", o_of[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_ghost", o_ov[0], 0);
    end
    exp_q[0].delete();
    direct("t5_post", 8'h12, 8'h34, 1, 0, 0, 0, 8'h47, 0, 0);

    // randomized streams on every configuration
    for (int i = 0; i < NI; i++) begin
      n_sent[i] = 0; n_recv[i] = 0; exp_q[i].delete();
    end
    cyc = 0;
    busy = 1'b1;
    while (busy && cyc < 60000) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        t_iv[i] = (n_sent[i] < NVEC) && ($urandom_range(0, 3) != 0);
        t_or[i] = ($urandom_range(0, 3) != 0);
        rand_vec(i);
      end
      #1;
      for (int i = 0; i < NI; i++) step_book(i);
      busy = 1'b0;
      for (int i = 0; i < NI; i++)
        if (n_sent[i] < NVEC || exp_q[i].size() != 0) busy = 1'b1;
      cyc++;
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rand_inst%0d_count", i), n_recv[i], NVEC);
      check($sformatf("rand_inst%0d_leftover", i), exp_q[i].size(), 0);
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
